// File: rtl/uart_word_rx.sv
// 8N1 UART receiver with optional MSB-first assembly of four bytes per word.
// Inter-byte idle timeout silently discards a partial word.
module uart_word_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        sys_clk,
  input  logic        sw_0,
  input  logic        i_serial,
  input  logic        i_mode_select,
  output logic [7:0]  o_byte,
  output logic        o_byte_valid,
  output logic [31:0] o_word,
  output logic        o_word_valid,
  output logic        o_frame_err
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W   = $clog2(TO_CYC);

  localparam logic [CNT_W-1:0] HALF_M1 =
    CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 =
    CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0] TO_M1 =
    TO_W'(TO_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic [31:0]      r_acc;
  logic [1:0]       r_wcnt;
  logic [TO_W-1:0]  r_idle;

  logic w_rx;
  logic w_cnt_clr;
  logic w_shift_en;
  logic w_good;
  logic w_ferr;
  logic w_timeout;

  assign w_rx = r_sync[1];

  always_ff @(posedge sys_clk or negedge sw_0) begin
    if (!sw_0) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], i_serial};
  end

  always_ff @(posedge sys_clk or negedge sw_0) begin
    if (!sw_0) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_good      = 1'b0;
    w_ferr      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_clr = 1'b1;
        if (!w_rx) w_state_nxt = S_START;
      end
      S_START: begin
        if (r_cnt == HALF_M1) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = w_rx ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit == 3'd7) w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (r_cnt == FULL_M1) begin
          w_cnt_clr = 1'b1;
          if (w_rx) begin
            w_good      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = S_WAIT_HIGH;
          end
        end
      end
      S_WAIT_HIGH: begin
        w_cnt_clr = 1'b1;
        if (w_rx) w_state_nxt = S_IDLE;
      end
      default: begin
        w_cnt_clr   = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sw_0) begin
    if (!sw_0) begin
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_cnt <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
      if (r_state == S_START) r_bit <= '0;
      else if (w_shift_en)    r_bit <= r_bit + 3'd1;
      if (w_shift_en) r_shift <= {w_rx, r_shift[7:1]};
    end
  end

  assign w_timeout = (r_state == S_IDLE) &&
                     (r_wcnt != 2'd0) &&
                     (r_idle == TO_M1);

  always_ff @(posedge sys_clk or negedge sw_0) begin
    if (!sw_0) begin
      r_idle <= '0;
    end else if (r_state != S_IDLE || r_wcnt == 2'd0 ||
                 w_timeout) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + TO_W'(1);
    end
  end

  // Word completes when the 2-bit count wraps 3 -> 0.
  always_ff @(posedge sys_clk or negedge sw_0) begin
    if (!sw_0) begin
      o_byte       <= '0;
      o_byte_valid <= 1'b0;
      o_word       <= '0;
      o_word_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      r_acc        <= '0;
      r_wcnt       <= '0;
    end else begin
      o_byte_valid <= 1'b0;
      o_word_valid <= 1'b0;
      o_frame_err  <= w_ferr;
      if (w_good) begin
        o_byte       <= r_shift;
        o_byte_valid <= 1'b1;
        if (i_mode_select) begin
          r_acc  <= {r_acc[23:0], r_shift};
          r_wcnt <= r_wcnt + 2'd1;
          if (r_wcnt == 2'd3) begin
            o_word       <= {r_acc[23:0], r_shift};
            o_word_valid <= 1'b1;
          end
        end else begin
          r_wcnt <= '0;
        end
      end else if (w_ferr || w_timeout) begin
        r_wcnt <= '0;
      end
    end
  end

endmodule

// File: doc/uart_word_rx.md
# uart_word_rx

Serial receive stage sitting directly downstream of the `word_to_byte_tx` serializer, on the `RsRx` line inside `top`. It deserializes 8N1 UART frames into bytes. In word mode it assembles four consecutive bytes, MSB first, into a 32-bit word. Valid strobes and framing-error flags are presented to the command logic of `top`.

## Interface
Parameters:
- `CLKS_PER_BIT`, 16: sys_clk cycles per UART bit. Must be even, ≥ 8, and equal to the transmitter's setting.
- `TIMEOUT_BITS`, 40: idle bit-times after which a partially assembled word is discarded.

Ports:
- `sys_clk`  in  1  system clock; all logic on the rising edge.
- `sw_0`  in  1  reset, asynchronous, active-low.
- `i_serial`  in  1  UART line, asynchronous, idle high.
- `i_mode_select`  in  1  0 = byte mode, 1 = word mode. Sampled at byte completion.
- `o_byte`  out  8  last received byte. Holds until the next good byte.
- `o_byte_valid`  out  1  one-cycle pulse per good byte, in both modes.
- `o_word`  out  32  last assembled word. Holds until the next word.
- `o_word_valid`  out  1  one-cycle pulse per completed word.
- `o_frame_err`  out  1  one-cycle pulse when a stop bit is sampled low.

## Operation
- Input synchronizer: `i_serial` passes through a 2-flop synchronizer (reset value 1). All decisions use the synchronized line `rx_s`.
- FSM states:
  - IDLE: on `rx_s` = 0, clear the bit counter and go to START.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. If `rx_s` = 1, the start was a glitch: return to IDLE, no output. Otherwise clear the counter and go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first, into the shift register. After the 8th sample go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - If 1: the byte is good. Go to IDLE.
    - If 0: pulse `o_frame_err`, drop the byte, clear the word byte count, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s` = 1, then go to IDLE. A line held low never produces a byte.
- Good-byte handling, in the same cycle:
  - Load `o_byte` and pulse `o_byte_valid`.
  - If `i_mode_select` = 1: shift the byte into the word accumulator (`acc = {acc[23:0], byte}`) and increment the 2-bit count. When the count wraps 3→0, load `o_word` from the new accumulator and pulse `o_word_valid` in the same cycle as `o_byte_valid`.
  - If `i_mode_select` = 0: clear the count and leave `o_word` unchanged.
- Inter-byte timeout:
  - While count ≠ 0 and the FSM is in IDLE, an idle counter runs. It resets on leaving IDLE.
  - After TIMEOUT_BITS*CLKS_PER_BIT cycles it clears the count. This is silent: no flag is raised.
- Mode change mid-word: switching to byte mode discards the partial word at the next byte completion. No word is emitted.
- Reset values: every output is 0. FSM in IDLE, count 0, accumulator 0.
- Reset mid-frame: all state is cleared immediately, including the synchronizer. After reset release, a line that is still low is treated as a new start edge. The resulting frame may then fail with a framing error.

## Timing
- Byte latency: `o_byte_valid` rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles after the first `sys_clk` edge that samples `i_serial` low (+0/+1 for the asynchronous input). For CLKS_PER_BIT = 16 this is 154 cycles.
- All outputs are registered; there are no combinational paths from inputs.
- The receiver is ready for the next start edge from the cycle after STOP.
  - Back-to-back frames with no idle time between the stop bit and the next start bit are received without loss.
- No flow control: a consumer must take each byte within one byte-time, or it is overwritten.
- `o_word_valid` and `o_frame_err` are never high in the same cycle.
- `o_byte_valid` and `o_frame_err` are never high in the same cycle.

## Test plan
Use CLKS_PER_BIT = 16 and a 10 ns clock.

1. Byte mode, frames 0x00, 0xAB, 0x10:
   - Expect three `o_byte_valid` pulses with `o_byte` = 0x00, 0xAB, 0x10, each 154 ±1 cycles after its start edge.
   - `o_word_valid` stays 0 throughout.
2. Word mode, bytes 0x00, 0xFF, 0x12, 0xCD back-to-back:
   - Expect four byte pulses and a single `o_word_valid` with `o_word` = 0x00FF12CD, coincident with the 4th byte pulse.
   - Then switch to byte mode and send 0x01: expect byte 0x01, with `o_word` still 0x00FF12CD.
3. Glitch: drive `i_serial` low for 5 cycles, then high. Expect no strobe of any kind, FSM back in IDLE, and a following 0x5A frame received correctly.
4. Framing error: send a frame of 0x3C with the stop bit low for a full bit-time, then the line high.
   - Expect one `o_frame_err` pulse, no `o_byte_valid`, and the word count cleared.
   - The next frame is received normally.
5. Timeout: in word mode send 0x11, 0x22, then idle for 41 bit-times, then send 0xA1, 0xB2, 0xC3, 0xD4.
   - Expect exactly one `o_word_valid`, with `o_word` = 0xA1B2C3D4.
6. Reset mid-frame: assert `sw_0` low in the middle of a frame's data bits.
   - All outputs read 0 immediately.
   - Release reset with the line high, send 0xE7, and expect `o_byte` = 0xE7.
